// File: rtl/alu_result_pipe.sv
// Selects one of NUM_OPS packed operation results and queues {result, zero, illegal}
// in a two-entry valid/ready FIFO with a sticky illegal-select flag.
module alu_result_pipe #(
  parameter int WIDTH   = 4,
  parameter int SEL_W   = 4,
  parameter int NUM_OPS = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [SEL_W-1:0]         in_sel,
  input  logic [NUM_OPS*WIDTH-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_result,
  output logic                     out_zero,
  output logic                     out_illegal,
  input  logic                     err_clr,
  output logic                     err_sticky,
  output logic [1:0]               occupancy
);

  localparam int DEPTH = 2;

  logic [WIDTH-1:0] chan [NUM_OPS];
  logic [WIDTH-1:0] sel_result;
  logic             sel_legal;
  logic             sel_zero;

  logic [WIDTH-1:0] result_reg  [DEPTH];
  logic             zero_reg    [DEPTH];
  logic             illegal_reg [DEPTH];
  logic             wr_ptr_reg, wr_ptr_next;
  logic             rd_ptr_reg, rd_ptr_next;
  logic [1:0]       count_reg, count_next;
  logic             err_reg, err_next;
  logic             push, pop;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_OPS; gi++) begin : g_chan
      assign chan[gi] = in_data[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // Out-of-range selects fall back to channel 0 and are flagged.
  always_comb begin
    sel_legal  = ({1'b0, in_sel} < (SEL_W+1)'(NUM_OPS));
    sel_result = chan[0];
    for (int k = 1; k < NUM_OPS; k++) begin
      if ({1'b0, in_sel} == (SEL_W+1)'(k)) begin
        sel_result = chan[k];
      end
    end
    sel_zero = (sel_result == '0);
  end

  assign in_ready  = (count_reg != 2'd2);
  assign out_valid = (count_reg != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    err_next    = err_reg;
    if (push) begin
      wr_ptr_next = ~wr_ptr_reg;
    end
    if (pop) begin
      rd_ptr_next = ~rd_ptr_reg;
    end
    case ({push, pop})
      2'b10:   count_next = count_reg + 2'd1;
      2'b01:   count_next = count_reg - 2'd1;
      default: count_next = count_reg;
    endcase
    // A new illegal push wins over a same-cycle clear.
    if (push && !sel_legal) begin
      err_next = 1'b1;
    end else if (err_clr) begin
      err_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
      err_reg    <= 1'b0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      err_reg    <= err_next;
    end
  end

  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic wr_en;
      assign wr_en = push && (wr_ptr_reg == 1'(gi));
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          result_reg[gi]  <= '0;
          zero_reg[gi]    <= 1'b0;
          illegal_reg[gi] <= 1'b0;
        end else if (wr_en) begin
          result_reg[gi]  <= sel_result;
          zero_reg[gi]    <= sel_zero;
          illegal_reg[gi] <= !sel_legal;
        end
      end
    end
  endgenerate

  // Head fields are gated so an empty buffer always presents zeros.
  assign out_result  = out_valid ? result_reg[rd_ptr_reg]  : '0;
  assign out_zero    = out_valid ? zero_reg[rd_ptr_reg]    : 1'b0;
  assign out_illegal = out_valid ? illegal_reg[rd_ptr_reg] : 1'b0;
  assign err_sticky  = err_reg;
  assign occupancy   = count_reg;

endmodule

// File: tb/tb_alu_result_pipe.sv
// Directed bench for alu_result_pipe: a default instance plus a NUM_OPS=12 instance
// sharing stimulus, each checked against hand-computed values.
module tb_alu_result_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [3:0]  in_sel = '0;
  logic [63:0] in_data = '0;
  logic        out_ready = 1'b0;
  logic        err_clr = 1'b0;

  logic        in_ready, out_valid, out_zero, out_illegal, err_sticky;
  logic [3:0]  out_result;
  logic [1:0]  occupancy;

  logic        in_ready12, out_valid12, out_zero12, out_illegal12, err_sticky12;
  logic [3:0]  out_result12;
  logic [1:0]  occupancy12;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_result_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_sel(in_sel), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_zero(out_zero), .out_illegal(out_illegal),
    .err_clr(err_clr), .err_sticky(err_sticky), .occupancy(occupancy)
  );

  alu_result_pipe #(.WIDTH(4), .SEL_W(4), .NUM_OPS(12)) dut12 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready12),
    .in_sel(in_sel), .in_data(in_data[47:0]), .out_valid(out_valid12), .out_ready(out_ready),
    .out_result(out_result12), .out_zero(out_zero12), .out_illegal(out_illegal12),
    .err_clr(err_clr), .err_sticky(err_sticky12), .occupancy(occupancy12)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_chan(input int k, input logic [3:0] v);
    in_data[k*4 +: 4] = v;
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    err_clr   = 1'b0;
    rst_n     = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [4:0] model_q[$];
  logic [3:0] exp_res;

  initial begin
    // Reset state
    #2;
    check_eq("rst_occ", occupancy, 0);
    check_eq("rst_valid", out_valid, 0);
    check_eq("rst_result", out_result, 0);
    check_eq("rst_zero", out_zero, 0);
    check_eq("rst_illegal", out_illegal, 0);
    check_eq("rst_err", err_sticky, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("rel_in_ready", in_ready, 1);

    // Single transfer
    in_data = 64'h1111_1111_1111_1111;
    set_chan(2, 4'hA);
    in_sel = 4'h2; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    check_eq("single_valid", out_valid, 1);
    check_eq("single_result", out_result, 4'hA);
    check_eq("single_zero", out_zero, 0);
    check_eq("single_occ", occupancy, 1);
    in_valid = 1'b0;
    tick();
    check_eq("single_drain_occ", occupancy, 0);
    check_eq("single_drain_result", out_result, 0);
    check_eq("single_drain_valid", out_valid, 0);

    // Backpressure
    do_reset();
    in_data = 64'h2222_2222_2222_2222;
    set_chan(5, 4'h3); set_chan(7, 4'h5); set_chan(1, 4'h9);
    in_valid = 1'b1; in_sel = 4'd5;
    tick();
    in_sel = 4'd7;
    tick();
    check_eq("bp_occ2", occupancy, 2);
    check_eq("bp_in_ready", in_ready, 0);
    check_eq("bp_head", out_result, 4'h3);
    in_sel = 4'd1;
    tick();
    check_eq("bp_stall_occ", occupancy, 2);
    check_eq("bp_stable_head", out_result, 4'h3);
    out_ready = 1'b1;
    tick();
    check_eq("bp_pop1_occ", occupancy, 1);
    check_eq("bp_second", out_result, 4'h5);
    tick();
    check_eq("bp_pushpop_occ", occupancy, 1);
    check_eq("bp_third", out_result, 4'h9);
    in_valid = 1'b0;
    tick();
    check_eq("bp_empty_occ", occupancy, 0);
    tick();
    check_eq("bp_idle_pop_occ", occupancy, 0);

    // Zero flag
    do_reset();
    in_data = 64'h0765_4321_FEDC_BA98;
    set_chan(15, 4'h0);
    in_sel = 4'hF; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check_eq("zero_result", out_result, 0);
    check_eq("zero_flag", out_zero, 1);
    check_eq("zero_illegal", out_illegal, 0);
    check_eq("zero12_result", out_result12, 4'h8);
    check_eq("zero12_illegal", out_illegal12, 1);

    // Illegal select on the 12-channel instance
    do_reset();
    in_data = 64'h3333_3333_3333_3333;
    set_chan(0, 4'h7); set_chan(13, 4'h2);
    in_sel = 4'hD; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    check_eq("ill12_result", out_result12, 4'h7);
    check_eq("ill12_flag", out_illegal12, 1);
    check_eq("ill12_err", err_sticky12, 1);
    check_eq("ill16_result", out_result, 4'h2);
    check_eq("ill16_err", err_sticky, 0);
    in_sel = 4'hE; err_clr = 1'b1;
    tick();
    check_eq("ill12_clr_lose", err_sticky12, 1);
    in_valid = 1'b0;
    tick();
    err_clr = 1'b0;
    check_eq("ill12_clr", err_sticky12, 0);
    tick();
    check_eq("ill12_clr_hold", err_sticky12, 0);

    // Simultaneous push/pop at occupancy 1
    do_reset();
    model_q.delete();
    in_data = {$urandom, $urandom};
    in_sel = 4'($urandom_range(15, 0));
    in_valid = 1'b1;
    exp_res = in_data[in_sel*4 +: 4];
    model_q.push_back({exp_res == 4'h0, exp_res});
    tick();
    check_eq("pp_start_occ", occupancy, 1);
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_data = {$urandom, $urandom};
      in_sel = 4'($urandom_range(15, 0));
      if (i == 7) in_data[in_sel*4 +: 4] = 4'h0;
      exp_res = in_data[in_sel*4 +: 4];
      void'(model_q.pop_front());
      model_q.push_back({exp_res == 4'h0, exp_res});
      tick();
      check_eq($sformatf("pp%0d_occ", i), occupancy, 1);
      check_eq($sformatf("pp%0d_result", i), out_result, model_q[0][3:0]);
      check_eq($sformatf("pp%0d_zero", i), out_zero, model_q[0][4]);
    end

    // Reset at occupancy 2
    do_reset();
    in_data = 64'h4444_4444_4444_4444;
    in_sel = 4'd3; in_valid = 1'b1;
    tick();
    tick();
    check_eq("rst2_pre_occ", occupancy, 2);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rst2_occ", occupancy, 0);
    check_eq("rst2_valid", out_valid, 0);
    check_eq("rst2_result", out_result, 0);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("rst2_in_ready", in_ready, 1);
    tick();
    check_eq("rst2_no_stale", out_valid, 0);
    @(negedge clk);
    set_chan(6, 4'hC);
    in_sel = 4'd6; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check_eq("rst2_first_push", out_result, 4'hC);
    check_eq("rst2_first_occ", occupancy, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
